// File: rtl/cache_controller.sv
// Cache controller between the MEM stage, a 2-way data cache and the SRAM controller.
// Read hits complete in the request cycle; read misses fetch a 64-bit block from SRAM
// and fill the cache; stores are written through to SRAM and invalidate a hit line.
module cache_controller #(
   parameter int unsigned ADDR_BASE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [17:0] cache_address,
   output logic [63:0] cache_write_data,
   input  logic [31:0] cache_read_data,
   input  logic        cache_hit,
   output logic        cache_write_en,
   output logic        cache_invalidate,
   output logic        cache_lru_update,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_read_en,
   output logic        sram_write_en,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_SRAM = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] eff;

   // The pipeline holds address/wdata stable while ready=0, so they are used directly.
   assign eff              = address - 32'(ADDR_BASE);
   assign cache_address    = eff[19:2];
   assign sram_address     = eff;
   assign sram_wdata       = wdata;
   assign cache_write_data = sram_rdata;

   // State register; reset returns to IDLE even in the middle of an SRAM transaction.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode; outputs are forced idle while reset is asserted.
   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      next_state       = state;
      rdata            = 32'd0;
      ready            = 1'b1;
      cache_write_en   = 1'b0;
      cache_invalidate = 1'b0;
      cache_lru_update = 1'b0;
      sram_read_en     = 1'b0;
      sram_write_en    = 1'b0;

      if (rst) begin
         case (state)
            IDLE: begin
               if (MEM_W_EN) begin
                  // Store wins over a simultaneous load.
                  ready            = 1'b0;
                  sram_write_en    = 1'b1;
                  cache_invalidate = cache_hit;
                  next_state       = WR_SRAM;
               end else if (MEM_R_EN) begin
                  if (cache_hit) begin
                     rdata            = cache_read_data;
                     cache_lru_update = 1'b1;
                  end else begin
                     ready        = 1'b0;
                     sram_read_en = 1'b1;
                     next_state   = RD_MISS;
                  end
               end
            end

            RD_MISS: begin
               sram_read_en = 1'b1;
               if (sram_ready) begin
                  // Fill the block and forward the requested word in the same cycle.
                  cache_write_en = 1'b1;
                  rdata          = eff[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                  next_state     = IDLE;
               end else begin
                  ready = 1'b0;
               end
            end

            WR_SRAM: begin
               sram_write_en = 1'b1;
               if (sram_ready) begin
                  next_state = IDLE;
               end else begin
                  ready = 1'b0;
               end
            end

            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller; the bench plays both the cache
// (cache_hit / cache_read_data) and the SRAM controller (sram_ready / sram_rdata).
module tb_cache_controller;

   logic        clk;
   logic        rst;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] cache_address;
   logic [63:0] cache_write_data;
   logic [31:0] cache_read_data;
   logic        cache_hit;
   logic        cache_write_en;
   logic        cache_invalidate;
   logic        cache_lru_update;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_read_en;
   logic        sram_write_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   int checks = 0;
   int errors = 0;

   cache_controller #(.ADDR_BASE(1024)) dut (
      .clk              (clk),
      .rst              (rst),
      .MEM_R_EN         (MEM_R_EN),
      .MEM_W_EN         (MEM_W_EN),
      .address          (address),
      .wdata            (wdata),
      .rdata            (rdata),
      .ready            (ready),
      .cache_address    (cache_address),
      .cache_write_data (cache_write_data),
      .cache_read_data  (cache_read_data),
      .cache_hit        (cache_hit),
      .cache_write_en   (cache_write_en),
      .cache_invalidate (cache_invalidate),
      .cache_lru_update (cache_lru_update),
      .sram_address     (sram_address),
      .sram_wdata       (sram_wdata),
      .sram_read_en     (sram_read_en),
      .sram_write_en    (sram_write_en),
      .sram_rdata       (sram_rdata),
      .sram_ready       (sram_ready)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b0;
      MEM_R_EN        = 1'b0;
      MEM_W_EN        = 1'b0;
      address         = 32'h0;
      wdata           = 32'h0;
      cache_read_data = 32'h0;
      cache_hit       = 1'b0;
      sram_rdata      = 64'h0;
      sram_ready      = 1'b0;

      // Reset state.
      #12;
      check("rst_ready", ready, 1);
      check("rst_rdata", rdata, 0);
      check("rst_enables", {sram_read_en, sram_write_en, cache_write_en, cache_invalidate, cache_lru_update}, 0);
      rst = 1'b1;
      step();
      check("idle_ready", ready, 1);

      // 1. Load 0x400 misses; five cycles of ready=0, then the fill.
      address  = 32'h0000_0400;
      MEM_R_EN = 1'b1;
      #1;
      check("t1_cache_addr", cache_address, 18'h0);
      check("t1_sram_addr", sram_address, 32'h0);
      check("t1_rd_en", sram_read_en, 1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t1_wait%0d_ready", i), ready, 0);
         step();
      end
      sram_ready = 1'b1;
      sram_rdata = 64'hBBBB_0002_AAAA_0001;
      #1;
      check("t1_fill_ready", ready, 1);
      check("t1_fill_rdata", rdata, 32'hAAAA_0001);
      check("t1_fill_wen", cache_write_en, 1);
      check("t1_fill_wdata", cache_write_data, 64'hBBBB_0002_AAAA_0001);
      check("t1_fill_lru", cache_lru_update, 0);
      step();
      sram_ready      = 1'b0;
      cache_hit       = 1'b1;
      cache_read_data = 32'hAAAA_0001;
      #1;
      check("t1_rehit_ready", ready, 1);
      check("t1_rehit_rdata", rdata, 32'hAAAA_0001);
      check("t1_rehit_lru", cache_lru_update, 1);
      check("t1_rehit_rd_en", sram_read_en, 0);

      // 2. Load 0x404 hits in the filled block.
      step();
      address         = 32'h0000_0404;
      cache_read_data = 32'hBBBB_0002;
      #1;
      check("t2_cache_addr", cache_address, 18'h1);
      check("t2_rdata", rdata, 32'hBBBB_0002);
      check("t2_ready", ready, 1);
      check("t2_lru", cache_lru_update, 1);

      // 3. Store to 0x400 while it is cached.
      step();
      MEM_R_EN  = 1'b0;
      MEM_W_EN  = 1'b1;
      address   = 32'h0000_0400;
      wdata     = 32'hDEAD_BEEF;
      cache_hit = 1'b1;
      #1;
      check("t3_inval", cache_invalidate, 1);
      check("t3_wr_en", sram_write_en, 1);
      check("t3_wdata", sram_wdata, 32'hDEAD_BEEF);
      check("t3_ready", ready, 0);
      step();
      cache_hit = 1'b0;
      #1;
      check("t3_inval_once", cache_invalidate, 0);
      check("t3_wr_hold", sram_write_en, 1);
      check("t3_wait_ready", ready, 0);
      step();
      sram_ready = 1'b1;
      #1;
      check("t3_done_ready", ready, 1);
      check("t3_done_no_fill", cache_write_en, 0);
      step();
      sram_ready = 1'b0;
      MEM_W_EN   = 1'b0;
      MEM_R_EN   = 1'b1;
      #1;
      check("t3_reload_miss", sram_read_en, 1);
      check("t3_reload_ready", ready, 0);
      step();
      sram_ready = 1'b1;
      sram_rdata = 64'h1111_2222_DEAD_BEEF;
      #1;
      check("t3_reload_rdata", rdata, 32'hDEAD_BEEF);
      step();
      sram_ready = 1'b0;
      MEM_R_EN   = 1'b0;

      // 4. Store to an address that is not cached.
      MEM_W_EN = 1'b1;
      address  = 32'h0001_2344;
      wdata    = 32'h0BAD_F00D;
      #1;
      check("t4_cache_addr", cache_address, 18'h047D1);
      check("t4_sram_addr", sram_address, 32'h0001_1F44);
      check("t4_inval", cache_invalidate, 0);
      check("t4_wr_en", sram_write_en, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t4_hold%0d", i), {sram_write_en, ready}, 2'b10);
      end
      sram_ready = 1'b1;
      #1;
      check("t4_done_ready", ready, 1);
      step();
      sram_ready = 1'b0;
      MEM_W_EN   = 1'b0;
      #1;
      check("t4_idle", {ready, sram_write_en}, 2'b10);

      // 5. Reset in the middle of a miss, then a fresh miss that is dropped mid-way.
      MEM_R_EN = 1'b1;
      address  = 32'h0000_0404;
      step();
      step();
      check("t5_in_miss", sram_read_en, 1);
      rst = 1'b0;
      #1;
      check("t5_rst_rd_en", sram_read_en, 0);
      check("t5_rst_ready", ready, 1);
      MEM_R_EN = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check("t5_post_ready", ready, 1);
      check("t5_post_rd_en", sram_read_en, 0);
      MEM_R_EN = 1'b1;
      #1;
      check("t5_restart", {sram_read_en, ready}, 2'b10);
      step();
      MEM_R_EN = 1'b0;
      #1;
      check("t5_dropped_hold", sram_read_en, 1);
      step();
      sram_ready = 1'b1;
      sram_rdata = 64'hCAFE_0004_CAFE_0000;
      #1;
      check("t5_upper_word", rdata, 32'hCAFE_0004);
      check("t5_done_ready", ready, 1);
      step();
      sram_ready = 1'b0;
      #1;
      check("t5_idle", {ready, sram_read_en}, 2'b10);

      // 6. Load and store together: the store path wins.
      MEM_R_EN = 1'b1;
      MEM_W_EN = 1'b1;
      address  = 32'h0000_0800;
      #1;
      check("t6_wr_en", sram_write_en, 1);
      check("t6_rd_en", sram_read_en, 0);
      check("t6_ready", ready, 0);
      step();
      check("t6_rd_en_hold", {sram_read_en, sram_write_en}, 2'b01);
      sram_ready = 1'b1;
      #1;
      check("t6_done_ready", ready, 1);
      check("t6_no_fill", cache_write_en, 0);
      step();
      sram_ready = 1'b0;
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      #1;
      check("t6_idle", ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
